pushbutton_processor: RTL and testbench

//   Converts one raw, bouncy scoreboard pushbutton into two one-cycle command pulses.
//   A short press (released before 2 s) gives count_up.
//   A long press (held for 2 s) gives count_down.

---
 rtl/scoreboard_pkg.sv | 17 +
 rtl/pushbutton_debouncer.sv | 56 +++++
 rtl/pushbutton_processor.sv | 95 +++++++++
 tb/tb_pushbutton_processor.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/scoreboard_pkg.sv
// Shared types and default timing constants for the scoreboard pushbutton path.
`timescale 1ns / 1ps
package scoreboard_pkg;

    // Press FSM encoding
    typedef enum logic [1:0] {
        StIdle,
        StHeld,
        StLong
    } press_state_t;

    // Defaults in 1 kHz timebase cycles (1 cycle = 1 ms)
    localparam int unsigned DEBOUNCE_MS_DEF   = 20;
    localparam int unsigned LONG_PRESS_MS_DEF = 2000;
    localparam int unsigned CNT_W_DEF         = 12;

endpackage

// File: rtl/pushbutton_debouncer.sv
// Two-flop synchronizer followed by a stable-count debouncer.
// The debounced level follows the synchronized button only after it has
// differed for DEBOUNCE_MS consecutive cycles.
`timescale 1ns / 1ps
module pushbutton_debouncer
    import scoreboard_pkg::*;
#(
    parameter int unsigned DEBOUNCE_MS = DEBOUNCE_MS_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic clk_1khz,
    input  logic rst_i,
    input  logic pushbutton_i,
    output logic deb_o
);

    localparam logic [CNT_W-1:0] DebLast = CNT_W'(DEBOUNCE_MS - 1);

    logic             sync1_q;
    logic             btn_s_q;
    logic             deb_q;
    logic             deb_d;
    logic [CNT_W-1:0] deb_cnt_q;
    logic [CNT_W-1:0] deb_cnt_d;

    // Synchronizer, debounced level and stability counter
    always_ff @(posedge clk_1khz or negedge rst_i) begin
        if (!rst_i) begin
            sync1_q   <= 1'b0;
            btn_s_q   <= 1'b0;
            deb_q     <= 1'b0;
            deb_cnt_q <= '0;
        end else begin
            sync1_q   <= pushbutton_i;
            btn_s_q   <= sync1_q;
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    // Count while the input disagrees; accept the new level on the last count
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        if (btn_s_q != deb_q) begin
            if (deb_cnt_q == DebLast) begin
                deb_d = btn_s_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    assign deb_o = deb_q;

endmodule

// File: rtl/pushbutton_processor.sv
// Turns a raw scoreboard pushbutton into one-cycle command pulses:
// count_up for a short press, count_down once a press is held LONG_PRESS_MS.
`timescale 1ns / 1ps
module pushbutton_processor
    import scoreboard_pkg::*;
#(
    parameter int unsigned DEBOUNCE_MS   = DEBOUNCE_MS_DEF,
    parameter int unsigned LONG_PRESS_MS = LONG_PRESS_MS_DEF,
    parameter int unsigned CNT_W         = CNT_W_DEF
) (
    input  logic clk_1khz,
    input  logic rst_i,
    input  logic pushbutton_i,
    output logic count_up,
    output logic count_down
);

    localparam logic [CNT_W-1:0] HoldLast = CNT_W'(LONG_PRESS_MS - 1);

    logic             deb;
    press_state_t     state_q;
    press_state_t     state_d;
    logic [CNT_W-1:0] hold_cnt_q;
    logic [CNT_W-1:0] hold_cnt_d;
    logic             count_up_q;
    logic             count_up_d;
    logic             count_down_q;
    logic             count_down_d;

    pushbutton_debouncer #(
        .DEBOUNCE_MS (DEBOUNCE_MS),
        .CNT_W       (CNT_W)
    ) u_debouncer (
        .clk_1khz     (clk_1khz),
        .rst_i        (rst_i),
        .pushbutton_i (pushbutton_i),
        .deb_o        (deb)
    );

    // FSM state, hold counter and registered pulses
    always_ff @(posedge clk_1khz or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= StIdle;
            hold_cnt_q   <= '0;
            count_up_q   <= 1'b0;
            count_down_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            count_up_q   <= count_up_d;
            count_down_q <= count_down_d;
        end
    end

    // Press classification; the threshold check precedes the release check
    // so a release in the threshold cycle still yields count_down.
    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        count_up_d   = 1'b0;
        count_down_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                hold_cnt_d = '0;
                // deb is always low on entry to idle, so a high level is a rising edge
                if (deb) begin
                    state_d = StHeld;
                end
            end
            StHeld: begin
                if (hold_cnt_q == HoldLast) begin
                    count_down_d = 1'b1;
                    state_d      = StLong;
                end else if (!deb) begin
                    count_up_d = 1'b1;
                    state_d    = StIdle;
                end else if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            StLong: begin
                if (!deb) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign count_up   = count_up_q;
    assign count_down = count_down_q;

endmodule

// File: tb/tb_pushbutton_processor.sv
// Bench for pushbutton_processor: expected pulses are queued when a press is
// driven and matched (kind and cycle window) by a monitor as they appear.
`timescale 1ns / 1ps
module tb_pushbutton_processor;

    logic clk_1khz = 1'b0;
    logic rst_i = 1'b1;
    logic pushbutton_i = 1'b0;
    logic count_up;
    logic count_down;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct {
        bit is_down;
        int lo;
        int hi;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    pushbutton_processor dut (
        .clk_1khz     (clk_1khz),
        .rst_i        (rst_i),
        .pushbutton_i (pushbutton_i),
        .count_up     (count_up),
        .count_down   (count_down)
    );

    always #5 clk_1khz = ~clk_1khz;

    always @(posedge clk_1khz) cyc <= cyc + 1;

    // Every pulse must match the oldest queued expectation
    always @(negedge clk_1khz) begin
        if (count_up === 1'b1 || count_down === 1'b1) begin
            total++;
            if (count_up === 1'b1 && count_down === 1'b1) begin
                bad++;
                $display("FAIL exclusive: up=%b down=%b at cycle %0d, required not both high",
                         count_up, count_down, cyc);
            end else if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse: up=%b down=%b at cycle %0d, required no pulse",
                         count_up, count_down, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (count_down !== mon_e.is_down || cyc < mon_e.lo || cyc > mon_e.hi) begin
                    bad++;
                    $display("FAIL pulse_match: got down=%b at cycle %0d, required down=%b in [%0d,%0d]",
                             count_down, cyc, mon_e.is_down, mon_e.lo, mon_e.hi);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_1khz);
    endtask

    // Expected pulse visible 'at' cycles into the run, +/-2 cycles
    task automatic expect_pulse(input bit is_down, input int at);
        sb.push_back('{is_down, at - 2, at + 2});
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_1khz);
            total++;
            if ({count_up, count_down} !== 2'b00) begin
                bad++;
                $display("FAIL reset_outputs: up/down=%b, required 00", {count_up, count_down});
            end
        end
        rst_i = 1'b1;
        tick(30);
        total++;
        if (dut.u_debouncer.deb_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_deb: deb=%b, required 0", dut.u_debouncer.deb_o);
        end
    endtask

    task automatic test_short_bounce();
        int t;
        int d;
        int c1;
        t = 0;
        while (t < 8) begin
            pushbutton_i = ~pushbutton_i;
            d = $urandom_range(1, 2);
            tick(d);
            t += d;
        end
        pushbutton_i = 1'b1;
        tick(30);
        pushbutton_i = 1'b0;
        c1 = cyc;
        expect_pulse(1'b0, c1 + 23);
        tick(50);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL short_bounce_drain: pending=%0d, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_long_press();
        int c0;
        c0 = cyc;
        pushbutton_i = 1'b1;
        expect_pulse(1'b1, c0 + 2023);
        tick(2130);
        pushbutton_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick($urandom_range(1, 2));
            pushbutton_i = ~pushbutton_i;
        end
        pushbutton_i = 1'b0;
        tick(60);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL long_press_drain: pending=%0d, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_glitches();
        bit seen;
        for (int w = 1; w <= 19; w++) begin
            seen = 1'b0;
            pushbutton_i = 1'b1;
            repeat (w) begin
                @(negedge clk_1khz);
                if (dut.u_debouncer.deb_o !== 1'b0) seen = 1'b1;
            end
            pushbutton_i = 1'b0;
            repeat (30) begin
                @(negedge clk_1khz);
                if (dut.u_debouncer.deb_o !== 1'b0) seen = 1'b1;
            end
            total++;
            if (seen) begin
                bad++;
                $display("FAIL glitch_%0d: deb went high, required deb=0", w);
            end
        end
    endtask

    task automatic test_reset_mid_press();
        int c1;
        // Held, then released while in reset: no pulse afterwards
        pushbutton_i = 1'b1;
        tick(1000);
        total++;
        if (dut.u_debouncer.deb_o !== 1'b1) begin
            bad++;
            $display("FAIL held_deb: deb=%b, required 1", dut.u_debouncer.deb_o);
        end
        #2 rst_i = 1'b0;
        #1;
        total++;
        if ({count_up, count_down, dut.u_debouncer.deb_o} !== 3'b000) begin
            bad++;
            $display("FAIL async_clear: up/down/deb=%b, required 000",
                     {count_up, count_down, dut.u_debouncer.deb_o});
        end
        tick(3);
        pushbutton_i = 1'b0;
        tick(3);
        rst_i = 1'b1;
        tick(50);
        // Fresh clean press after reset
        pushbutton_i = 1'b1;
        tick(100);
        pushbutton_i = 1'b0;
        c1 = cyc;
        expect_pulse(1'b0, c1 + 23);
        tick(50);
        // Still held across reset release: counts as a new press
        pushbutton_i = 1'b1;
        tick(500);
        #2 rst_i = 1'b0;
        tick(3);
        rst_i = 1'b1;
        tick(100);
        pushbutton_i = 1'b0;
        c1 = cyc;
        expect_pulse(1'b0, c1 + 23);
        tick(50);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL reset_press_drain: pending=%0d, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_threshold();
        int c0;
        int c1;
        // 1999 cycles: just short of the threshold
        pushbutton_i = 1'b1;
        tick(1999);
        pushbutton_i = 1'b0;
        c1 = cyc;
        expect_pulse(1'b0, c1 + 23);
        tick(60);
        // 2000 cycles: release lands in the threshold cycle, count_down wins
        c0 = cyc;
        pushbutton_i = 1'b1;
        expect_pulse(1'b1, c0 + 2023);
        tick(2000);
        pushbutton_i = 1'b0;
        tick(60);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL threshold_drain: pending=%0d, required 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #1 rst_i = 1'b0;
        test_reset();
        test_short_bounce();
        test_long_press();
        test_glitches();
        test_reset_mid_press();
        test_threshold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
